avg_pool_2x2_row: RTL and testbench
===================================

# avg_pool_2x2_row

Downstream neighbour of the row-wise tanh activation stage: consumes successive activated rows of a conv feature map (one row = `No_of_Neurons` values, 24 for a LeNet C1 map) and produces a 2×2 average-pooled row of `No_of_Neurons/2` values per pair of input rows. It buffers the first row of each pair and, when the second row arrives, computes one pooled element per cycle through a single shared averager. It hands the pooled row to the next conv/FC stage.

## Interface
Parameters:
- `DataWidth`, 32: word width; signed two's complement Q16.16.
- `No_of_Neurons`, 24: input row length; must be even and ≥2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `RowValid`  in  1  one-cycle strobe; `Neurons` holds a valid row this cycle.
- `Neurons`  in  `DataWidth*No_of_Neurons`  input row; element i at `[i*DataWidth +: DataWidth]`.
- `InReady`  out  1  high when a `RowValid` strobe will be accepted.
- `Finished`  out  1  one-cycle pulse; the full pooled row is valid.
- `PooledNeurons`  out  `DataWidth*No_of_Neurons/2`  pooled row; element j at `[j*DataWidth +: DataWidth]`.

## Operation
- FSM states:
  - S_ROW0: await the first row. `InReady`=1. `RowValid` captures `Neurons` into `row_buf` → S_ROW1.
  - S_ROW1: await the second row. `InReady`=1. `RowValid` captures into `row_cur`, clears `col` to 0 → S_POOL.
  - S_POOL: `InReady`=0. Each cycle writes `PooledNeurons[col] = avg4(row_buf[2col], row_buf[2col+1], row_cur[2col], row_cur[2col+1])` and increments `col`. When `col` = N/2−1 → S_DONE.
  - S_DONE: `Finished`=1 for exactly one cycle, `InReady`=0 → S_ROW0.
- `RowValid` while `InReady`=0 is ignored. The row is dropped, with no error flag, and state is unchanged.
- `Neurons` is sampled only on the accepting edge. It may change freely otherwise.
- avg4 arithmetic:
  - Sign-extend the four operands to `DataWidth+2` bits and add exactly, with no overflow possible.
  - Arithmetic shift right by 2 (floor toward −∞). Keep the low `DataWidth` bits; the result always fits.
- `PooledNeurons` elements update progressively during S_POOL. They hold stable from S_DONE until the next S_POOL begins. Consumers sample on `Finished`.
- `col` width is clog2(N/2). It never wraps past N/2−1.
- Reset, including mid S_ROW1 or S_POOL: state → S_ROW0 and `col` → 0. `row_buf`, `row_cur` and `PooledNeurons` → 0; `Finished` → 0. Any partially buffered pair is discarded.
- `InReady` is decoded from state, so it reads 1 during and immediately after reset.
- `RowValid` asserted in the same cycle as `reset` is ignored.

## Timing
- Reset values: `Finished`=0, `PooledNeurons`=0, `InReady`=1.
- Let the second-row accept edge be E0:
  - Elements 0..N/2−1 are written at edges E1..E(N/2).
  - `Finished` is high between E(N/2) and E(N/2+1); with N=24 that is 12 cycles after E0.
  - `InReady` returns high after E(N/2+1).
- Minimum pair period: 2 accept cycles + N/2 pool cycles + 1 done cycle (15 cycles for N=24).
- `Finished` and state are registered. `InReady` is combinational from state only, with no path from `RowValid`.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_WIDTH`=32 and `FRAC_BITS`=16.
  - Q16.16 constants `Q_ONE`=32'h0001_0000 and `Q_HALF`=32'h0000_8000.
  - The pool FSM state enum (S_ROW0, S_ROW1, S_POOL, S_DONE).
- One sub-module, `avg4_q16`: a combinational 4-input Q16.16 averager, parameterised on `DataWidth`. It is instantiated once and muxed by `col`.

## Test plan
- Uniform: both rows all 32'h0001_0000 (1.0) → all 12 outputs 32'h0001_0000. `Finished` pulses exactly 12 cycles after the second accept edge, width 1.
- Mixed signs:
  - row0 pairs (1.0, −1.0 = 32'hFFFF_0000) and row1 pairs (0.5, 0.5) → every output 32'h0000_4000 (0.25).
  - row1 element 23 set to 32'h0001_0000 → output 11 = 32'h0000_6000 (0.375).
- Rounding and extremes:
  - Window {32'hFFFF_FFFF, 0, 0, 0} → 32'hFFFF_FFFF (floor).
  - Window of four 32'h7FFF_FFFF → 32'h7FFF_FFFF.
  - Window of four 32'h8000_0000 → 32'h8000_0000.
- Ignored strobe: `RowValid` pulsed with a garbage row during S_POOL and S_DONE → outputs match the uniform case. The next two accepted rows pool correctly.
- Reset mid-pool: assert `reset` at pool cycle 5 → next cycle `PooledNeurons`=0, `Finished`=0, `InReady`=1. A following pair of 1.0 rows yields all 32'h0001_0000.
- Back-to-back: three row pairs driven at minimum spacing → three `Finished` pulses exactly 15 cycles apart with the correct per-pair averages.

Source files
------------

// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN datapath stages: Q16.16 number format
// constants and the state encoding of the 2x2 average-pool row FSM.
// No ports (package).
// ----------------------------------------------------------------------------
package cnn_pkg;

   localparam int          DATA_WIDTH = 32;
   localparam int          FRAC_BITS  = 16;

   localparam logic [31:0] Q_ONE      = 32'h0001_0000;  // 1.0
   localparam logic [31:0] Q_HALF     = 32'h0000_8000;  // 0.5

   typedef enum logic [1:0] {
      S_ROW0 = 2'd0,   // waiting for the first row of a pair
      S_ROW1 = 2'd1,   // waiting for the second row of a pair
      S_POOL = 2'd2,   // producing one pooled element per cycle
      S_DONE = 2'd3    // pooled row complete, Finished pulse
   } pool_state_t;

endpackage : cnn_pkg

// File: rtl/avg4_q16.sv
// ----------------------------------------------------------------------------
// avg4_q16
// Combinational average of four signed fixed-point words. The sum is formed
// two bits wider than the operands so it can never overflow, then divided by
// four with floor rounding (toward minus infinity).
//
// Ports:
//   i_a, i_b, i_c, i_d  in   DataWidth  signed operands
//   o_avg               out  DataWidth  floor((a+b+c+d)/4)
// ----------------------------------------------------------------------------
module avg4_q16
   import cnn_pkg::*;
#(
   parameter int DataWidth = DATA_WIDTH
) (
   input  logic [DataWidth-1:0] i_a,
   input  logic [DataWidth-1:0] i_b,
   input  logic [DataWidth-1:0] i_c,
   input  logic [DataWidth-1:0] i_d,
   output logic [DataWidth-1:0] o_avg
);

   logic [DataWidth+1:0] w_sum;

   assign w_sum = {{2{i_a[DataWidth-1]}}, i_a}
                + {{2{i_b[DataWidth-1]}}, i_b}
                + {{2{i_c[DataWidth-1]}}, i_c}
                + {{2{i_d[DataWidth-1]}}, i_d};

   // Dropping the two LSBs of a two's complement sum is an arithmetic shift
   // right by 2, i.e. floor division by 4. The mean of four in-range values
   // is itself in range, so the top DataWidth bits of the shifted sum are exact.
   assign o_avg = w_sum[DataWidth+1:2];

endmodule : avg4_q16

// File: rtl/avg_pool_2x2_row.sv
// ----------------------------------------------------------------------------
// avg_pool_2x2_row
// 2x2 average pooling over successive rows of a feature map. The first row of
// each pair is buffered; once the second row arrives the pooled row is built
// one element per cycle through a single shared averager, then Finished
// pulses for one cycle.
//
// Ports:
//   clk            in   1                   rising-edge clock
//   reset          in   1                   synchronous, active-high
//   RowValid       in   1                   strobe: Neurons holds a row
//   Neurons        in   DataWidth*N         input row, element i at [i*DW +: DW]
//   InReady        out  1                   a RowValid strobe will be accepted
//   Finished       out  1                   one-cycle pulse: pooled row valid
//   PooledNeurons  out  DataWidth*N/2       pooled row, element j at [j*DW +: DW]
// ----------------------------------------------------------------------------
module avg_pool_2x2_row
   import cnn_pkg::*;
#(
   parameter int DataWidth     = DATA_WIDTH,
   parameter int No_of_Neurons = 24            // must be even and >= 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 RowValid,
   input  logic [DataWidth*No_of_Neurons-1:0]   Neurons,
   output logic                                 InReady,
   output logic                                 Finished,
   output logic [DataWidth*No_of_Neurons/2-1:0] PooledNeurons
);

   localparam int              NumOut  = No_of_Neurons / 2;
   localparam int              ColW    = (NumOut > 1) ? $clog2(NumOut) : 1;
   localparam logic [ColW-1:0] LastCol = ColW'(NumOut - 1);

   pool_state_t          r_state;
   logic [ColW-1:0]      r_col;
   logic                 r_finished;
   logic [DataWidth-1:0] r_row_buf [No_of_Neurons];
   logic [DataWidth-1:0] r_row_cur [No_of_Neurons];
   logic [DataWidth-1:0] r_pooled  [NumOut];

   logic [DataWidth-1:0] w_avg;

   // Single averager, steered to the 2x2 window selected by r_col.
   avg4_q16 #(
      .DataWidth (DataWidth)
   ) u_avg4 (
      .i_a   (r_row_buf[{r_col, 1'b0}]),
      .i_b   (r_row_buf[{r_col, 1'b1}]),
      .i_c   (r_row_cur[{r_col, 1'b0}]),
      .i_d   (r_row_cur[{r_col, 1'b1}]),
      .o_avg (w_avg)
   );

   // NOTE: sequential state uses non-blocking (<=) assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_ROW0;
         r_col      <= '0;
         r_finished <= 1'b0;
         // NOTE: the row buffers and pooled row are cleared on reset because
         // PooledNeurons is directly visible and must read zero after reset;
         // this keeps them in flops rather than RAM.
         for (int i = 0; i < No_of_Neurons; i++) begin
            r_row_buf[i] <= '0;
            r_row_cur[i] <= '0;
         end
         for (int j = 0; j < NumOut; j++) begin
            r_pooled[j] <= '0;
         end
      end else begin
         r_finished <= 1'b0;
         case (r_state)
            S_ROW0: begin
               if (RowValid) begin
                  for (int i = 0; i < No_of_Neurons; i++) begin
                     r_row_buf[i] <= Neurons[i*DataWidth +: DataWidth];
                  end
                  r_state <= S_ROW1;
               end
            end
            S_ROW1: begin
               if (RowValid) begin
                  for (int i = 0; i < No_of_Neurons; i++) begin
                     r_row_cur[i] <= Neurons[i*DataWidth +: DataWidth];
                  end
                  r_col   <= '0;
                  r_state <= S_POOL;
               end
            end
            S_POOL: begin
               r_pooled[r_col] <= w_avg;
               // r_col holds at the last column instead of wrapping.
               if (r_col == LastCol) begin
                  r_finished <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_ROW0;
            end
            default: begin
               r_state <= S_ROW0;
            end
         endcase
      end
   end

   // Decoded from state alone: no combinational path from RowValid.
   assign InReady  = (r_state == S_ROW0) || (r_state == S_ROW1);
   assign Finished = r_finished;

   for (genvar g = 0; g < NumOut; g++) begin : g_pack
      assign PooledNeurons[g*DataWidth +: DataWidth] = r_pooled[g];
   end

endmodule : avg_pool_2x2_row

// File: tb/tb_avg_pool_2x2_row.sv
// ----------------------------------------------------------------------------
// tb_avg_pool_2x2_row
// Self-checking bench for avg_pool_2x2_row (DataWidth=32, N=24). Expected
// pooled rows are computed by a reference model when each pair is driven and
// queued; a monitor pops and compares them whenever Finished pulses.
// ----------------------------------------------------------------------------
module tb_avg_pool_2x2_row;
   import cnn_pkg::*;

   localparam int DW = 32;
   localparam int N  = 24;
   localparam int NO = N / 2;
   localparam int RW = DW * N;
   localparam int PW = DW * NO;

   logic          clk = 1'b0;
   logic          reset;
   logic          RowValid;
   logic [RW-1:0] Neurons;
   logic          InReady;
   logic          Finished;
   logic [PW-1:0] PooledNeurons;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            cyc      = 0;
   int            e0_cyc   = 0;
   logic [PW-1:0] exp_q [$];

   avg_pool_2x2_row #(
      .DataWidth     (DW),
      .No_of_Neurons (N)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .RowValid      (RowValid),
      .Neurons       (Neurons),
      .InReady       (InReady),
      .Finished      (Finished),
      .PooledNeurons (PooledNeurons)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------- model
   function automatic logic [PW-1:0] pool_model(input logic [RW-1:0] r0,
                                                input logic [RW-1:0] r1);
      logic [PW-1:0] res;
      longint        s, q;
      res = '0;
      for (int j = 0; j < NO; j++) begin
         s = longint'($signed(r0[(2*j)*DW   +: DW]))
           + longint'($signed(r0[(2*j+1)*DW +: DW]))
           + longint'($signed(r1[(2*j)*DW   +: DW]))
           + longint'($signed(r1[(2*j+1)*DW +: DW]));
         q = s / 4;                          // truncates toward zero
         if (s < 0 && (s % 4) != 0) q = q - 1;  // adjust to floor
         res[j*DW +: DW] = q[DW-1:0];
      end
      return res;
   endfunction

   function automatic logic [RW-1:0] fill_row(input logic [DW-1:0] v);
      logic [RW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = $urandom;
      return r;
   endfunction

   // ------------------------------------------------------------ scoreboard
   always @(negedge clk) begin
      if (reset === 1'b0 && Finished === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks = n_checks + 1;
            n_fail   = n_fail + 1;
            $display("FAIL sb_unexpected_finished: got Finished=1, required no pending pair");
         end else begin
            logic [PW-1:0] exp_row;
            exp_row = exp_q.pop_front();
            for (int j = 0; j < NO; j++) begin
               n_checks = n_checks + 1;
               if (PooledNeurons[j*DW +: DW] !== exp_row[j*DW +: DW]) begin
                  n_fail = n_fail + 1;
                  $display("FAIL sb_elem%0d: got %h, required %h", j,
                           PooledNeurons[j*DW +: DW], exp_row[j*DW +: DW]);
               end
            end
         end
      end
   end

   // --------------------------------------------------------------- drivers
   // Called at a negedge; returns at the negedge after the second accept edge.
   task automatic send_pair(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                            input bit push);
      n_checks = n_checks + 1;
      if (InReady !== 1'b1) begin
         n_fail = n_fail + 1;
         $display("FAIL inready_row0: got %b, required 1", InReady);
      end
      RowValid = 1'b1;
      Neurons  = r0;
      @(negedge clk);
      n_checks = n_checks + 1;
      if (InReady !== 1'b1) begin
         n_fail = n_fail + 1;
         $display("FAIL inready_row1: got %b, required 1", InReady);
      end
      Neurons = r1;
      if (push) exp_q.push_back(pool_model(r0, r1));
      @(negedge clk);
      e0_cyc   = cyc;
      RowValid = 1'b0;
      Neurons  = rand_row();
   endtask

   // Waits (bounded) for Finished; optionally strobes RowValid with garbage
   // on every cycle, including the Finished cycle itself.
   task automatic wait_finished(input bit poke, output bit seen, output int lat);
      seen = 1'b0;
      lat  = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (poke) begin
            RowValid = 1'b1;
            Neurons  = rand_row();
         end
         @(negedge clk);
         if (Finished === 1'b1) begin
            seen = 1'b1;
            lat  = cyc - e0_cyc;
         end
      end
      if (poke && seen) begin
         RowValid = 1'b1;
         Neurons  = rand_row();
      end
   endtask

   // Checks the standard completion timing, leaves the bench at the negedge
   // after the S_DONE cycle with RowValid low.
   task automatic finish_and_check(input string name, input bit poke,
                                   output int fin_cyc);
      bit seen;
      int lat;
      wait_finished(poke, seen, lat);
      fin_cyc = cyc;
      n_checks = n_checks + 1;
      if (!seen) begin
         n_fail = n_fail + 1;
         $display("FAIL %s_timeout: got no Finished in 40 cycles, required pulse", name);
      end else if (lat != NO) begin
         n_fail = n_fail + 1;
         $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, NO);
      end
      @(negedge clk);
      RowValid = 1'b0;
      n_checks = n_checks + 1;
      if (Finished !== 1'b0 || InReady !== 1'b1) begin
         n_fail = n_fail + 1;
         $display("FAIL %s_after_done: got Finished=%b InReady=%b, required 0/1",
                  name, Finished, InReady);
      end
   endtask

   // ----------------------------------------------------------------- tests
   task automatic test_reset();
      reset    = 1'b1;
      RowValid = 1'b1;          // strobe during reset must be ignored
      Neurons  = rand_row();
      repeat (2) @(negedge clk);
      n_checks = n_checks + 1;
      if (InReady !== 1'b1 || Finished !== 1'b0 || PooledNeurons !== '0) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_during: got InReady=%b Finished=%b Pooled!=0:%b, required 1/0/0",
                  InReady, Finished, PooledNeurons !== '0);
      end
      reset    = 1'b0;
      RowValid = 1'b0;
      @(negedge clk);
      n_checks = n_checks + 1;
      if (InReady !== 1'b1 || Finished !== 1'b0 || PooledNeurons !== '0) begin
         n_fail = n_fail + 1;
         $display("FAIL reset_after: got InReady=%b Finished=%b Pooled!=0:%b, required 1/0/0",
                  InReady, Finished, PooledNeurons !== '0);
      end
   endtask

   task automatic test_uniform();
      int fc;
      send_pair(fill_row(Q_ONE), fill_row(Q_ONE), 1'b1);
      n_checks = n_checks + 1;
      if (InReady !== 1'b0) begin
         n_fail = n_fail + 1;
         $display("FAIL uniform_inready_pool: got %b, required 0", InReady);
      end
      finish_and_check("uniform", 1'b0, fc);
   endtask

   task automatic test_mixed_signs();
      logic [RW-1:0] r0, r1;
      int fc;
      for (int i = 0; i < N; i++) r0[i*DW +: DW] = (i % 2 == 0) ? Q_ONE : 32'hFFFF_0000;
      r1 = fill_row(32'h0000_8000);
      send_pair(r0, r1, 1'b1);
      finish_and_check("mixed", 1'b0, fc);
      n_checks = n_checks + 1;
      if (PooledNeurons[0 +: DW] !== 32'h0000_4000) begin
         n_fail = n_fail + 1;
         $display("FAIL mixed_elem0: got %h, required 00004000", PooledNeurons[0 +: DW]);
      end
      r1[23*DW +: DW] = Q_ONE;
      send_pair(r0, r1, 1'b1);
      finish_and_check("mixed23", 1'b0, fc);
      n_checks = n_checks + 1;
      if (PooledNeurons[11*DW +: DW] !== 32'h0000_6000) begin
         n_fail = n_fail + 1;
         $display("FAIL mixed_elem11: got %h, required 00006000", PooledNeurons[11*DW +: DW]);
      end
   endtask

   task automatic test_extremes();
      logic [RW-1:0] r0, r1;
      int fc;
      r0 = rand_row();
      r1 = rand_row();
      r0[0*DW +: DW] = 32'hFFFF_FFFF; r0[1*DW +: DW] = '0;
      r1[0*DW +: DW] = '0;            r1[1*DW +: DW] = '0;
      r0[2*DW +: DW] = 32'h7FFF_FFFF; r0[3*DW +: DW] = 32'h7FFF_FFFF;
      r1[2*DW +: DW] = 32'h7FFF_FFFF; r1[3*DW +: DW] = 32'h7FFF_FFFF;
      r0[4*DW +: DW] = 32'h8000_0000; r0[5*DW +: DW] = 32'h8000_0000;
      r1[4*DW +: DW] = 32'h8000_0000; r1[5*DW +: DW] = 32'h8000_0000;
      send_pair(r0, r1, 1'b1);
      finish_and_check("extremes", 1'b0, fc);
      n_checks = n_checks + 1;
      if (PooledNeurons[0 +: DW] !== 32'hFFFF_FFFF ||
          PooledNeurons[DW +: DW] !== 32'h7FFF_FFFF ||
          PooledNeurons[2*DW +: DW] !== 32'h8000_0000) begin
         n_fail = n_fail + 1;
         $display("FAIL extremes_const: got %h %h %h, required ffffffff 7fffffff 80000000",
                  PooledNeurons[0 +: DW], PooledNeurons[DW +: DW], PooledNeurons[2*DW +: DW]);
      end
   endtask

   task automatic test_ignored_strobe();
      int fc;
      send_pair(fill_row(Q_ONE), fill_row(Q_ONE), 1'b1);
      finish_and_check("ignored", 1'b1, fc);
      n_checks = n_checks + 1;
      if (PooledNeurons !== {NO{Q_ONE}}) begin
         n_fail = n_fail + 1;
         $display("FAIL ignored_uniform: got %h, required all 00010000", PooledNeurons);
      end
      send_pair(rand_row(), rand_row(), 1'b1);
      finish_and_check("ignored_next", 1'b0, fc);
   endtask

   task automatic test_reset_mid_pool();
      bit seen;
      int fc;
      send_pair(rand_row(), rand_row(), 1'b0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks = n_checks + 1;
      if (PooledNeurons !== '0 || Finished !== 1'b0 || InReady !== 1'b1) begin
         n_fail = n_fail + 1;
         $display("FAIL midreset_state: got Pooled!=0:%b Finished=%b InReady=%b, required 0/0/1",
                  PooledNeurons !== '0, Finished, InReady);
      end
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (Finished === 1'b1) seen = 1'b1;
      end
      n_checks = n_checks + 1;
      if (seen) begin
         n_fail = n_fail + 1;
         $display("FAIL midreset_no_finish: got Finished pulse, required none");
      end
      send_pair(fill_row(Q_ONE), fill_row(Q_ONE), 1'b1);
      finish_and_check("midreset_next", 1'b0, fc);
   endtask

   task automatic test_back_to_back();
      int fin [3];
      for (int p = 0; p < 3; p++) begin
         send_pair(rand_row(), rand_row(), 1'b1);
         finish_and_check("b2b", 1'b0, fin[p]);
      end
      for (int p = 1; p < 3; p++) begin
         n_checks = n_checks + 1;
         if (fin[p] - fin[p-1] != 15) begin
            n_fail = n_fail + 1;
            $display("FAIL b2b_period%0d: got %0d cycles, required 15", p, fin[p] - fin[p-1]);
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      RowValid = 1'b0;
      Neurons  = '0;
      @(negedge clk);
      test_reset();
      test_uniform();
      test_mixed_signs();
      test_extremes();
      test_ignored_strobe();
      test_reset_mid_pool();
      test_back_to_back();
      repeat (2) @(negedge clk);
      n_checks = n_checks + 1;
      if (exp_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL sb_drain: got %0d pending rows, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_avg_pool_2x2_row
